// File: rtl/tdes_key_sched_pkg.sv
// rtl/tdes_key_sched_pkg.sv - shared types, widths and shift tables for the DES key schedule
// Purpose: FSM state enum, C/D, subkey and key widths, per-round rotation
//          amounts for both directions, and 28-bit rotate helpers.
// Ports:   none (package).
// Bit convention: vectors are descending; DES bit n of a W-bit vector is v[W-n].
package tdes_ks_pkg;

    localparam int CD_W  = 28;
    localparam int KN_W  = 48;
    localparam int KEY_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ks_state_t;

    // Encrypt: left-rotate amounts producing C1..C16 from C0.
    localparam logic [1:0] SHIFT_ENC [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Decrypt: right-rotate amounts walking C16(=C0)..C1; entry j undoes encrypt step 16-j.
    localparam logic [1:0] SHIFT_DEC [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] v, input logic [1:0] n);
        logic [2*CD_W-1:0] t;
        t = {v, v} << n;
        return t[2*CD_W-1:CD_W];
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] v, input logic [1:0] n);
        logic [2*CD_W-1:0] t;
        t = {v, v} >> n;
        return t[CD_W-1:0];
    endfunction

endpackage

// File: rtl/tdes_key_sched_if.sv
// rtl/tdes_key_sched_if.sv - start/subkey handshake bundle between TDES control, key schedule and round datapath
// Purpose: groups start/key/decrypt/busy/done and the kn valid/ready stream.
// Modports: master = control/consumer side, slave = key schedule.
// Optional: TDES_KS_PARITY_CHK_EN adds key_par_err (slave output).
interface tdes_ks_if;
    import tdes_ks_pkg::*;

    logic              start;
    logic [KEY_W-1:0]  key;
    logic              decrypt;
    logic              busy;
    logic              kn_valid;
    logic              kn_ready;
    logic [KN_W-1:0]   kn;
    logic [3:0]        kn_round;
    logic              done;

`ifdef TDES_KS_PARITY_CHK_EN
    logic              key_par_err;

    modport master (
        output start, key, decrypt, kn_ready,
        input  busy, kn_valid, kn, kn_round, done, key_par_err
    );
    modport slave (
        input  start, key, decrypt, kn_ready,
        output busy, kn_valid, kn, kn_round, done, key_par_err
    );
`else
    modport master (
        output start, key, decrypt, kn_ready,
        input  busy, kn_valid, kn, kn_round, done
    );
    modport slave (
        input  start, key, decrypt, kn_ready,
        output busy, kn_valid, kn, kn_round, done
    );
`endif

endinterface

// File: rtl/tdes_key_sched_pc1.sv
// rtl/tdes_key_sched_pc1.sv - DES permuted choice 1 (64 -> 2x28), drops parity bits
// Ports: i_key  [63:0] key, DES bit n at i_key[64-n]
//        o_c0x  [27:0] C0, DES bit 1 of C at o_c0x[27]
//        o_d0x  [27:0] D0, same ordering
module pc1
    import tdes_ks_pkg::*;
(
    input  logic [KEY_W-1:0] i_key,
    output logic [CD_W-1:0]  o_c0x,
    output logic [CD_W-1:0]  o_d0x
);

    localparam int TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    logic [2*CD_W-1:0] w_perm;

    for (genvar i = 0; i < 2*CD_W; i++) begin : g_bit
        localparam int SRC = KEY_W - TAB[i];
        assign w_perm[2*CD_W-1-i] = i_key[SRC];
    end

    assign o_c0x = w_perm[2*CD_W-1:CD_W];
    assign o_d0x = w_perm[CD_W-1:0];

endmodule

// File: rtl/tdes_key_sched_pc2.sv
// rtl/tdes_key_sched_pc2.sv - DES permuted choice 2 (56 -> 48 subkey)
// Ports: i_cd [55:0] {C,D}, DES bit 1 at i_cd[55]
//        o_kn [47:0] subkey, DES bit 1 at o_kn[47]
module pc2
    import tdes_ks_pkg::*;
(
    input  logic [2*CD_W-1:0] i_cd,
    output logic [KN_W-1:0]   o_kn
);

    localparam int TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    for (genvar i = 0; i < KN_W; i++) begin : g_bit
        localparam int SRC = 2*CD_W - TAB[i];
        assign o_kn[KN_W-1-i] = i_cd[SRC];
    end

endmodule

// File: rtl/tdes_key_sched.sv
// rtl/tdes_key_sched.sv - DES key schedule sequencer issuing 16 PC2 subkeys over a valid/ready stream
// Purpose: on start, loads C/D from PC1(key), then issues one subkey per accepted
//          transfer in encrypt (K1..K16) or decrypt (K16..K1) order, then pulses done.
// Ports:   clk, rst_n (async active-low)
//          ks (tdes_ks_if.slave): start/key/decrypt in, busy/done out,
//          kn/kn_round/kn_valid out with kn_ready in.
// Optional: TDES_KS_PARITY_CHK_EN adds key_par_err, set at accept when any key
//           byte has even parity.
module tdes_key_sched
    import tdes_ks_pkg::*;
#(
    parameter int NROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    tdes_ks_if.slave    ks
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

    ks_state_t          r_state;
    ks_state_t          w_state_nxt;
    logic [CD_W-1:0]    r_c;
    logic [CD_W-1:0]    r_d;
    logic               r_dir;
    logic [3:0]         r_rcnt;
    logic [KN_W-1:0]    r_kn;
    logic [3:0]         r_kn_round;
    logic               r_kn_valid;
    logic               r_done;

    logic [CD_W-1:0]    w_c0;
    logic [CD_W-1:0]    w_d0;
    logic [CD_W-1:0]    w_c_sh;
    logic [CD_W-1:0]    w_d_sh;
    logic [KN_W-1:0]    w_kn;
    logic [1:0]         w_amt;
    logic               w_load;
    logic               w_issue;
    logic               w_finish;

    pc1 u_pc1 (
        .i_key (ks.key),
        .o_c0x (w_c0),
        .o_d0x (w_d0)
    );

    assign w_amt  = r_dir ? SHIFT_DEC[r_rcnt] : SHIFT_ENC[r_rcnt];
    assign w_c_sh = r_dir ? rotr28(r_c, w_amt) : rotl28(r_c, w_amt);
    assign w_d_sh = r_dir ? rotr28(r_d, w_amt) : rotl28(r_d, w_amt);

    pc2 u_pc2 (
        .i_cd ({w_c_sh, w_d_sh}),
        .o_kn (w_kn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_issue     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                // The done cycle blocks acceptance so a new schedule never overlaps the pulse.
                if (ks.start && !r_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!r_kn_valid || ks.kn_ready) begin
                    w_issue = 1'b1;
                    if (r_rcnt == LAST_ROUND) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ks.kn_ready) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c        <= '0;
            r_d        <= '0;
            r_dir      <= 1'b0;
            r_rcnt     <= '0;
            r_kn       <= '0;
            r_kn_round <= '0;
            r_kn_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_c    <= w_c0;
                r_d    <= w_d0;
                r_dir  <= ks.decrypt;
                r_rcnt <= '0;
            end
            if (w_issue) begin
                r_c        <= w_c_sh;
                r_d        <= w_d_sh;
                r_kn       <= w_kn;
                r_kn_round <= r_rcnt;
                r_kn_valid <= 1'b1;
                r_rcnt     <= r_rcnt + 4'd1;
            end
            if (w_finish) begin
                r_kn_valid <= 1'b0;
            end
        end
    end

    assign ks.busy     = (r_state != IDLE);
    assign ks.kn_valid = r_kn_valid;
    assign ks.kn       = r_kn;
    assign ks.kn_round = r_kn_round;
    assign ks.done     = r_done;

`ifdef TDES_KS_PARITY_CHK_EN
    logic [7:0] w_byte_odd;
    logic       r_key_par_err;

    for (genvar b = 0; b < 8; b++) begin : g_par
        assign w_byte_odd[b] = ^ks.key[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_par_err <= 1'b0;
        end else if (w_load) begin
            r_key_par_err <= ~&w_byte_odd;
        end
    end

    assign ks.key_par_err = r_key_par_err;
`endif

endmodule

// File: tb/tb_tdes_key_sched.sv
// tb/tb_tdes_key_sched.sv - randomized self-checking bench for tdes_key_sched against a behavioural DES key schedule
module tb_tdes_key_sched;
    import tdes_ks_pkg::*;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdes_ks_if ks ();

    tdes_key_sched #(.NROUNDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ks)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: textbook DES schedule, C_r/D_r as C0/D0 rotated by the cumulative shift.
    int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                       19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int ROT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] exp_ks [16];
    logic [47:0] got_ks [16];
    logic [47:0] enc_seq [16];

    task automatic model(input logic [63:0] k, input logic dec);
        logic [27:0] c0, d0;
        logic [55:0] cd;
        logic [47:0] sub [16];
        int cum;
        for (int i = 0; i < 28; i++) begin
            c0[27-i] = k[64-PC1_T[i]];
            d0[27-i] = k[64-PC1_T[28+i]];
        end
        cum = 0;
        for (int r = 0; r < 16; r++) begin
            cum += ROT_T[r];
            for (int j = 0; j < 28; j++) begin
                cd[55-j] = c0[27-((j+cum)%28)];
                cd[27-j] = d0[27-((j+cum)%28)];
            end
            for (int b = 0; b < 48; b++) begin
                sub[r][47-b] = cd[56-PC2_T[b]];
            end
        end
        for (int r = 0; r < 16; r++) begin
            exp_ks[r] = dec ? sub[15-r] : sub[r];
        end
    endtask

    // Called at a negedge with the bench idle; returns at the negedge where done is high.
    task automatic run_sched(input logic [63:0] k, input logic dec, input bit rnd_ready,
                             input bit poke_start, input string tag);
        int n = 0;
        int cyc = 0;
        bit stall = 0;
        bit rdy;
        logic [47:0] last_kn = '0;
        logic [3:0]  last_rnd = '0;
        model(k, dec);
        ks.key = k;
        ks.decrypt = dec;
        ks.start = 1'b1;
        @(posedge clk); @(negedge clk);
        ks.start = 1'b0;
        ks.key = {$urandom, $urandom};
        ks.decrypt = ~dec;
        check({tag, "_busy_after_accept"}, 64'(ks.busy), 64'd1);
        check({tag, "_valid_after_accept"}, 64'(ks.kn_valid), 64'd0);
        @(posedge clk); @(negedge clk);
        while (n < 16 && cyc < 400) begin
            if (stall) begin
                check({tag, "_hold_kn"}, 64'(ks.kn), 64'(last_kn));
                check({tag, "_hold_round"}, 64'(ks.kn_round), 64'(last_rnd));
                check({tag, "_hold_valid"}, 64'(ks.kn_valid), 64'd1);
            end
            check({tag, "_no_early_done"}, 64'(ks.done), 64'd0);
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            ks.kn_ready = rdy;
            if (poke_start) begin
                ks.start = (n == 3 || n == 15);
                ks.key = ~k;
                ks.decrypt = ~dec;
            end
            if (ks.kn_valid && rdy) begin
                check($sformatf("%s_kn_%0d", tag, n), 64'(ks.kn), 64'(exp_ks[n]));
                check($sformatf("%s_round_%0d", tag, n), 64'(ks.kn_round), 64'(n));
                got_ks[n] = ks.kn;
                n++;
            end
            stall = ks.kn_valid && !rdy;
            last_kn = ks.kn;
            last_rnd = ks.kn_round;
            cyc++;
            @(posedge clk); @(negedge clk);
        end
        ks.start = 1'b0;
        check({tag, "_subkey_count"}, 64'(n), 64'd16);
        if (!rnd_ready) check({tag, "_valid_cycles"}, 64'(cyc), 64'd16);
        check({tag, "_done_pulse"}, 64'(ks.done), 64'd1);
        check({tag, "_valid_drop"}, 64'(ks.kn_valid), 64'd0);
        check({tag, "_busy_drop"}, 64'(ks.busy), 64'd0);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(ks.done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        rst_n = 1'b0;
        ks.start = 1'b0;
        ks.key = '0;
        ks.decrypt = 1'b0;
        ks.kn_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(ks.busy), 64'd0);
        check("rst_valid", 64'(ks.kn_valid), 64'd0);
        check("rst_kn", 64'(ks.kn), 64'd0);
        check("rst_round", 64'(ks.kn_round), 64'd0);
        check("rst_done", 64'(ks.done), 64'd0);
`ifdef TDES_KS_PARITY_CHK_EN
        check("rst_par_err", 64'(ks.key_par_err), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_sched(KEY_A, 1'b0, 1'b0, 1'b0, "enc");
        check("enc_first_vector", 64'(got_ks[0]), 64'(K1_A));
        check("enc_last_vector", 64'(got_ks[15]), 64'(K16_A));
        for (int i = 0; i < 16; i++) enc_seq[i] = got_ks[i];
        idle_cycle("enc");

        run_sched(KEY_A, 1'b1, 1'b0, 1'b0, "dec");
        check("dec_first_vector", 64'(got_ks[0]), 64'(K16_A));
        check("dec_last_vector", 64'(got_ks[15]), 64'(K1_A));
        for (int i = 0; i < 16; i++)
            check($sformatf("dec_reverse_%0d", i), 64'(got_ks[i]), 64'(enc_seq[15-i]));
        idle_cycle("dec");

        for (int t = 0; t < 4; t++) begin
            run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b0, $sformatf("bp%0d", t));
            idle_cycle("bp");
        end

        run_sched(KEY_A, 1'b0, 1'b1, 1'b1, "poke");
        for (int i = 0; i < 16; i++)
            check($sformatf("poke_seq_%0d", i), 64'(got_ks[i]), 64'(enc_seq[i]));

        // start presented in the done cycle must be ignored
        ks.start = 1'b1;
        ks.key = KEY_A;
        ks.decrypt = 1'b0;
        @(posedge clk); @(negedge clk);
        ks.start = 1'b0;
        check("start_in_done_ignored", 64'(ks.busy), 64'd0);
        check("start_in_done_no_valid", 64'(ks.kn_valid), 64'd0);
        run_sched({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, "after_done");
        idle_cycle("after_done");

        // reset mid-schedule
        ks.key = KEY_A;
        ks.decrypt = 1'b0;
        ks.kn_ready = 1'b1;
        ks.start = 1'b1;
        @(posedge clk); @(negedge clk);
        ks.start = 1'b0;
        wait_cyc = 0;
        while (!(ks.kn_valid && ks.kn_round == 4'd7) && wait_cyc < 50) begin
            @(posedge clk); @(negedge clk);
            wait_cyc++;
        end
        check("rst_mid_reached_round7", 64'(ks.kn_round), 64'd7);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(ks.busy), 64'd0);
        check("rst_mid_valid", 64'(ks.kn_valid), 64'd0);
        check("rst_mid_kn", 64'(ks.kn), 64'd0);
        check("rst_mid_round", 64'(ks.kn_round), 64'd0);
        check("rst_mid_done", 64'(ks.done), 64'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check("rst_mid_no_done", 64'(ks.done), 64'd0);
            check("rst_mid_idle", 64'(ks.busy), 64'd0);
        end
        run_sched(KEY_A, 1'b0, 1'b0, 1'b0, "post_rst");
        check("post_rst_first_vector", 64'(got_ks[0]), 64'(K1_A));
        idle_cycle("post_rst");

`ifdef TDES_KS_PARITY_CHK_EN
        run_sched(KEY_A, 1'b0, 1'b1, 1'b0, "par_ok");
        check("par_ok_flag", 64'(ks.key_par_err), 64'd0);
        idle_cycle("par_ok");
        run_sched(KEY_A ^ 64'd1, 1'b0, 1'b1, 1'b0, "par_bad");
        check("par_bad_flag", 64'(ks.key_par_err), 64'd1);
        idle_cycle("par_bad");
        check("par_bad_holds", 64'(ks.key_par_err), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
